shift_rs_sched: RTL and testbench

SHIFT_RS_SCHED -- requirements
Module: shift_rs_sched

---
 rtl/shift_rs_sched.sv | 207 ++++++++++++++++++++
 tb/tb_shift_rs_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rs_sched.sv
// shift_rs_sched: reservation station for one shifter, oldest-ready single issue.
// Optional define SHIFT_RS_BYPASS_EN: capture a same-cycle CDB hit at allocation.
package shift_rs_pkg;
  typedef logic [31:0] word32_t;
  typedef logic [3:0]  rs_tag_t;

  localparam rs_tag_t TAG_NONE = 4'd0;
  localparam rs_tag_t ALU_0    = 4'd1;
  localparam rs_tag_t ALU_1    = 4'd2;
  localparam rs_tag_t SHIFT_0  = 4'd3;
  localparam rs_tag_t SHIFT_1  = 4'd4;
  localparam rs_tag_t MUL_0    = 4'd5;
  localparam rs_tag_t LSU_0    = 4'd6;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2
  } shift_op_t;

  typedef struct packed {
    logic    valid;
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

  typedef struct packed {
    shift_op_t op;
    word32_t   v1;
    rs_tag_t   t1;
    logic      r1;
    word32_t   v2;
    rs_tag_t   t2;
    logic      r2;
  } rs_entry_t;
endpackage

module shift_rs_sched
  import shift_rs_pkg::*;
#(
  parameter int      DEPTH = 4,
  parameter rs_tag_t TAG   = SHIFT_1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  shift_op_t              alloc_op_i,
  input  word32_t                alloc_rs1_val_i,
  input  word32_t                alloc_rs2_val_i,
  input  rs_tag_t                alloc_rs1_tag_i,
  input  rs_tag_t                alloc_rs2_tag_i,
  input  logic                   alloc_rs1_rdy_i,
  input  logic                   alloc_rs2_rdy_i,
  input  cdb_t                   cdb_i,
  input  logic                   flush_i,
  output shift_op_t              oper_o,
  output word32_t                rs1_val_o,
  output word32_t                rs2_val_o,
  output logic                   ready_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);
  localparam int OW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("shift_rs_sched: DEPTH must be a power of two in 2..8");
  end
  if (TAG == TAG_NONE) begin : g_bad_tag
    $error("shift_rs_sched: TAG must name a real producer");
  end

  logic [DEPTH-1:0] r_valid;
  rs_entry_t        r_ent   [DEPTH];
  logic [DEPTH-1:0] r_older [DEPTH];

  logic [DEPTH-1:0] w_valid_nxt;
  rs_entry_t        w_ent_nxt   [DEPTH];
  logic [DEPTH-1:0] w_older_nxt [DEPTH];
  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_pick;
  logic [DEPTH-1:0] w_free_oh;
  logic             w_found;
  logic             w_alloc;
  rs_entry_t        w_new;
  logic [OW-1:0]    w_occ;

  assign alloc_ready_o = ~&r_valid;
  assign w_alloc       = alloc_valid_i & alloc_ready_o & ~flush_i;
  assign ready_o       = |w_pick;
  assign occupancy_o   = w_occ;

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++)
      w_occ = w_occ + OW'(r_valid[i]);
  end

  always_comb begin
    w_free_oh = '0;
    w_found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_free_oh[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  // r_older[i][j] set means entry j was allocated before entry i
  always_comb begin
    w_elig = '0;
    w_pick = '0;
    for (int i = 0; i < DEPTH; i++)
      w_elig[i] = r_valid[i] & r_ent[i].r1 & r_ent[i].r2;
    for (int i = 0; i < DEPTH; i++)
      w_pick[i] = w_elig[i] & ~|(r_older[i] & w_elig) & ~flush_i;
  end

  always_comb begin
    oper_o    = SLL;
    rs1_val_o = '0;
    rs2_val_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_pick[i]) begin
        oper_o    = r_ent[i].op;
        rs1_val_o = r_ent[i].v1;
        rs2_val_o = r_ent[i].v2;
      end
    end
  end

  always_comb begin
    w_new.op = alloc_op_i;
    w_new.v1 = alloc_rs1_val_i;
    w_new.t1 = alloc_rs1_tag_i;
    w_new.r1 = alloc_rs1_rdy_i;
    w_new.v2 = alloc_rs2_val_i;
    w_new.t2 = alloc_rs2_tag_i;
    w_new.r2 = alloc_rs2_rdy_i;
`ifdef SHIFT_RS_BYPASS_EN
    if (cdb_i.valid && !alloc_rs1_rdy_i &&
        alloc_rs1_tag_i == cdb_i.tag) begin
      w_new.v1 = cdb_i.val;
      w_new.r1 = 1'b1;
    end
    if (cdb_i.valid && !alloc_rs2_rdy_i &&
        alloc_rs2_tag_i == cdb_i.tag) begin
      w_new.v2 = cdb_i.val;
      w_new.r2 = 1'b1;
    end
`endif
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ent_nxt[i] = r_ent[i];
      if (r_valid[i] && cdb_i.valid) begin
        if (!r_ent[i].r1 && r_ent[i].t1 == cdb_i.tag) begin
          w_ent_nxt[i].v1 = cdb_i.val;
          w_ent_nxt[i].r1 = 1'b1;
        end
        if (!r_ent[i].r2 && r_ent[i].t2 == cdb_i.tag) begin
          w_ent_nxt[i].v2 = cdb_i.val;
          w_ent_nxt[i].r2 = 1'b1;
        end
      end
      if (w_alloc && w_free_oh[i])
        w_ent_nxt[i] = w_new;
    end
  end

  // a new entry is younger than every survivor and older than nobody
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_older_nxt[i] = r_older[i];
      if (w_alloc) begin
        w_older_nxt[i] = r_older[i] & ~w_free_oh;
        if (w_free_oh[i])
          w_older_nxt[i] = r_valid & ~w_pick;
      end
    end
  end

  always_comb begin
    w_valid_nxt = r_valid & ~w_pick;
    if (w_alloc)
      w_valid_nxt = w_valid_nxt | w_free_oh;
    if (flush_i)
      w_valid_nxt = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i]   <= '0;
        r_older[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i]   <= w_ent_nxt[i];
        r_older[i] <= w_older_nxt[i];
      end
    end
  end
endmodule

// File: tb/tb_shift_rs_sched.sv
// tb_shift_rs_sched: scoreboard bench for the shifter reservation station.
// Expected issues are queued at stimulus time and matched at each issue pulse.
module tb_shift_rs_sched;
  import shift_rs_pkg::*;

  typedef struct packed {
    shift_op_t op;
    word32_t   v1;
    word32_t   v2;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      alloc_valid;
  logic      alloc_ready;
  shift_op_t alloc_op;
  word32_t   a_v1, a_v2;
  rs_tag_t   a_t1, a_t2;
  logic      a_r1, a_r2;
  cdb_t      cdb;
  logic      flush;
  shift_op_t oper_o;
  word32_t   rs1_val_o, rs2_val_o;
  logic      ready_o;
  logic [2:0] occ;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  shift_rs_sched #(.DEPTH(4), .TAG(SHIFT_1)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .alloc_valid_i  (alloc_valid),
    .alloc_ready_o  (alloc_ready),
    .alloc_op_i     (alloc_op),
    .alloc_rs1_val_i(a_v1),
    .alloc_rs2_val_i(a_v2),
    .alloc_rs1_tag_i(a_t1),
    .alloc_rs2_tag_i(a_t2),
    .alloc_rs1_rdy_i(a_r1),
    .alloc_rs2_rdy_i(a_r2),
    .cdb_i          (cdb),
    .flush_i        (flush),
    .oper_o         (oper_o),
    .rs1_val_o      (rs1_val_o),
    .rs2_val_o      (rs2_val_o),
    .ready_o        (ready_o),
    .occupancy_o    (occ)
  );

  always @(negedge clk) begin
    if (rst_n && ready_o) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL issue_unexpected: got op=%0d rs1=%h rs2=%h, required no issue",
                 oper_o, rs1_val_o, rs2_val_o);
      end else begin
        m_e = q.pop_front();
        if ({oper_o, rs1_val_o, rs2_val_o} !== m_e) begin
          n_bad++;
          $display("FAIL issue_data: got op=%0d rs1=%h rs2=%h, required op=%0d rs1=%h rs2=%h",
                   oper_o, rs1_val_o, rs2_val_o, m_e.op, m_e.v1, m_e.v2);
        end
      end
    end
  end

  function automatic exp_t mk(input shift_op_t op, input word32_t v1, input word32_t v2);
    exp_t e;
    e.op = op;
    e.v1 = v1;
    e.v2 = v2;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb.valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drv_alloc(input shift_op_t op,
                           input word32_t v1, input rs_tag_t t1, input logic r1,
                           input word32_t v2, input rs_tag_t t2, input logic r2);
    alloc_valid = 1'b1;
    alloc_op    = op;
    a_v1 = v1; a_t1 = t1; a_r1 = r1;
    a_v2 = v2; a_t2 = t2; a_r2 = r2;
  endtask

  task automatic drv_cdb(input rs_tag_t t, input word32_t v);
    cdb.valid = 1'b1;
    cdb.tag   = t;
    cdb.val   = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    drv_alloc(SRA, 32'h1234, TAG_NONE, 1'b1, 32'h5, TAG_NONE, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_ready: got %b required 0", ready_o);
    end
    n_cmp++;
    if (occ !== 3'd0) begin
      n_bad++; $display("FAIL rst_occ: got %0d required 0", occ);
    end
    n_cmp++;
    if (alloc_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_alloc_ready: got %b required 1", alloc_ready);
    end
    n_cmp++;
    if ({oper_o, rs1_val_o, rs2_val_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_outputs: got op=%0d rs1=%h rs2=%h required all 0",
               oper_o, rs1_val_o, rs2_val_o);
    end
    tick();
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_srl();
    drv_alloc(SRL, 32'h80400201, TAG_NONE, 1'b1, 32'd4, TAG_NONE, 1'b1);
    q.push_back(mk(SRL, 32'h80400201, 32'd4));
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1 || occ !== 3'd1) begin
      n_bad++;
      $display("FAIL srl_issue: got ready=%b occ=%0d required ready=1 occ=1", ready_o, occ);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0 || occ !== 3'd0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL srl_drain: got ready=%b occ=%0d pending=%0d required 0/0/0",
               ready_o, occ, q.size());
    end
  endtask

  task automatic test_out_of_order();
    drv_alloc(SLL, 32'h10, TAG_NONE, 1'b1, 32'h0, ALU_0, 1'b0);
    tick();
    drv_alloc(SRA, 32'hF0000000, TAG_NONE, 1'b1, 32'd2, TAG_NONE, 1'b1);
    q.push_back(mk(SRA, 32'hF0000000, 32'd2));
    tick();
    idle();
    drv_cdb(ALU_0, 32'd3);
    q.push_back(mk(SLL, 32'h10, 32'd3));
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++; $display("FAIL ooo_b_issue: got ready=%b required 1", ready_o);
    end
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++; $display("FAIL ooo_a_issue: got ready=%b required 1", ready_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0 || occ !== 3'd0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL ooo_drain: got ready=%b occ=%0d pending=%0d required 0/0/0",
               ready_o, occ, q.size());
    end
  endtask

  task automatic test_full_and_age();
    rs_tag_t   tg [4];
    shift_op_t op [4];
    tg[0] = ALU_1; tg[1] = MUL_0; tg[2] = LSU_0; tg[3] = ALU_1;
    op[0] = SLL;   op[1] = SRL;   op[2] = SRA;   op[3] = SRA;
    for (int i = 0; i < 4; i++) begin
      drv_alloc(op[i], 32'h0, tg[i], 1'b0, 32'(10 + i), TAG_NONE, 1'b1);
      tick();
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (alloc_ready !== 1'b0 || occ !== 3'd4) begin
      n_bad++;
      $display("FAIL full_state: got alloc_ready=%b occ=%0d required 0/4", alloc_ready, occ);
    end
    drv_alloc(SLL, 32'hDEAD, TAG_NONE, 1'b1, 32'd1, TAG_NONE, 1'b1);
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (occ !== 3'd4 || ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL full_ignore: got occ=%0d ready=%b required 4/0", occ, ready_o);
    end
    drv_cdb(MUL_0, 32'h55);
    q.push_back(mk(SRL, 32'h55, 32'd11));
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1 || alloc_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_wake: got ready=%b alloc_ready=%b required 1/0", ready_o, alloc_ready);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (alloc_ready !== 1'b1 || occ !== 3'd3 || ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL full_freed: got alloc_ready=%b occ=%0d ready=%b required 1/3/0",
               alloc_ready, occ, ready_o);
    end
    drv_alloc(SRL, 32'h99, TAG_NONE, 1'b1, 32'd7, TAG_NONE, 1'b1);
    drv_cdb(ALU_1, 32'h22);
    q.push_back(mk(SLL, 32'h22, 32'd10));
    q.push_back(mk(SRA, 32'h22, 32'd13));
    q.push_back(mk(SRL, 32'h99, 32'd7));
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b1) begin
        n_bad++; $display("FAIL age_issue%0d: got ready=%b required 1", k, ready_o);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0 || occ !== 3'd1 || q.size() != 0) begin
      n_bad++;
      $display("FAIL age_drain: got ready=%b occ=%0d pending=%0d required 0/1/0",
               ready_o, occ, q.size());
    end
    flush = 1'b1;
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (occ !== 3'd0) begin
      n_bad++; $display("FAIL full_cleanup: got occ=%0d required 0", occ);
    end
  endtask

  task automatic test_dual_wake();
    drv_alloc(SRA, 32'h0, SHIFT_0, 1'b0, 32'h0, SHIFT_0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++; $display("FAIL dual_wait: got ready=%b required 0", ready_o);
    end
    drv_cdb(SHIFT_0, 32'h1F);
    q.push_back(mk(SRA, 32'h1F, 32'h1F));
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++; $display("FAIL dual_issue: got ready=%b required 1", ready_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (occ !== 3'd0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL dual_drain: got occ=%0d pending=%0d required 0/0", occ, q.size());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drv_alloc(SLL, 32'h0, ALU_0, 1'b0, 32'(i), TAG_NONE, 1'b1);
      tick();
    end
    idle();
    drv_cdb(ALU_0, 32'd5);
    tick();
    idle();
    flush = 1'b1;
    drv_alloc(SLL, 32'd1, TAG_NONE, 1'b1, 32'd1, TAG_NONE, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready: got ready=%b required 0", ready_o);
    end
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (occ !== 3'd0 || ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_occ: got occ=%0d ready=%b required 0/0", occ, ready_o);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b0) begin
        n_bad++; $display("FAIL flush_after%0d: got ready=%b required 0", k, ready_o);
      end
    end
  endtask

  task automatic test_bypass();
    drv_alloc(SRL, 32'h0, ALU_1, 1'b0, 32'd5, TAG_NONE, 1'b1);
    drv_cdb(ALU_1, 32'h77);
`ifdef SHIFT_RS_BYPASS_EN
    q.push_back(mk(SRL, 32'h77, 32'd5));
`endif
    tick();
    idle();
    @(negedge clk);
`ifdef SHIFT_RS_BYPASS_EN
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++; $display("FAIL bypass_issue: got ready=%b required 1", ready_o);
    end
`else
    n_cmp++;
    if (ready_o !== 1'b0 || occ !== 3'd1) begin
      n_bad++;
      $display("FAIL bypass_pending: got ready=%b occ=%0d required 0/1", ready_o, occ);
    end
    drv_cdb(ALU_1, 32'h78);
    q.push_back(mk(SRL, 32'h78, 32'd5));
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++; $display("FAIL bypass_late_issue: got ready=%b required 1", ready_o);
    end
`endif
    tick();
    @(negedge clk);
    n_cmp++;
    if (occ !== 3'd0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL bypass_drain: got occ=%0d pending=%0d required 0/0", occ, q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drv_alloc(SRA, 32'hAA, MUL_0, 1'b0, 32'(i), TAG_NONE, 1'b1);
      tick();
    end
    idle();
    drv_cdb(MUL_0, 32'd9);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (occ !== 3'd0 || ready_o !== 1'b0 || alloc_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_now: got occ=%0d ready=%b alloc_ready=%b required 0/0/1",
               occ, ready_o, alloc_ready);
    end
    tick();
    idle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b0 || occ !== 3'd0) begin
        n_bad++;
        $display("FAIL rstmid_after%0d: got ready=%b occ=%0d required 0/0", k, ready_o, occ);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    drv_alloc(SLL, '0, TAG_NONE, 1'b0, '0, TAG_NONE, 1'b0);
    alloc_valid = 1'b0;
    cdb.tag = TAG_NONE;
    cdb.val = '0;
    test_reset();
    test_srl();
    test_out_of_order();
    test_full_and_age();
    test_dual_wake();
    test_flush();
    test_bypass();
    test_reset_mid();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL final_queue: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
